fft_unload: RTL and testbench
=============================

// Module: fft_unload
// PURPOSE
// - Read-side companion to the FFT core. After fft_done, sweeps the result RAM via add_rd over
//   bins 0..2^(N-1)-1 (real input, so only the positive half is read).
// - Converts each complex bin to an L1 magnitude |re|+|im|.
// - Streams (bin, magnitude) beats downstream with valid/ready.
// - Reports the frame's peak bin for the display/SPI path.
// PARAMETERS
// - BIT_WIDTH  16  width of each real/imag component (signed two's complement)
// - N          9   log2 FFT length; NUM_BINS = 2^(N-1) = 256 bins streamed
// - SKIP_DC    1   1: bin 0 is streamed but excluded from peak search
// PORTS
// - clk          in   1            system clock
// - reset        in   1            synchronous, active-low reset
// - fft_done     in   1            FFT complete (level); result RAM stable while high
// - dout         in   2*BIT_WIDTH  FFT result {real[31:16], imag[15:0]}; valid 1 cycle after add_rd
// - add_rd       out  N            result-RAM read address (bin index)
// - rd_active    out  1            1 while this block owns add_rd (top-level address mux select)
// - mag_valid    out  1            output beat valid
// - mag_ready    in   1            downstream accepts beat
// - mag          out  BIT_WIDTH+1  unsigned |re|+|im|
// - mag_bin      out  N-1          bin index of current beat
// - mag_last     out  1            current beat is bin NUM_BINS-1
// - frame_done   out  1            one-cycle pulse after the last beat is accepted
// - peak_bin     out  N-1          bin of max mag in last frame; held until the next frame_done
// - peak_mag     out  BIT_WIDTH+1  value at peak_bin; held likewise
// BEHAVIOUR
// - Reset (reset==0 at a clk edge):
//   - state=IDLE; outputs add_rd=0, rd_active=0, mag_valid=0, frame_done=0, peak_bin=0, peak_mag=0.
//   - FIFO emptied; in-flight read discarded.
//   - Applies mid-frame with no partial output.
// - FSM states:
//   - IDLE: fft_done==1 -> READ; clear issue counter and running peak.
//   - READ: issue address i when FIFO free slots > in-flight reads, then i++.
//     After issuing NUM_BINS-1 -> DRAIN.
//   - DRAIN: stop issuing. When the last beat handshakes (mag_valid&mag_ready&mag_last):
//     pulse frame_done, latch peak_bin/peak_mag -> REARM.
//   - REARM: wait for fft_done==0 -> IDLE. A level-high fft_done never restarts a frame.
// - rd_active=1 in READ and DRAIN only.
// - fft_done changes while in READ/DRAIN are ignored.
// - Read latency:
//   - add_rd presented in cycle t; dout sampled at end of t+1.
//   - mag computed combinationally from dout and pushed to the FIFO at end of t+1.
//   - Earliest mag_valid is cycle t+2. Zero-backpressure throughput is 1 beat/cycle.
// - Backpressure: a 2-entry FIFO absorbs the 1-cycle RAM latency.
//   - Issue only if (FIFO occupancy + in-flight) < 2. The FIFO never overflows and no bin is dropped.
//   - Beat fields (mag, mag_bin, mag_last) are stable while mag_valid&&!mag_ready.
// - Arithmetic:
//   - abs(x) = x<0 ? -x : x, computed in BIT_WIDTH+1 bits, so abs(-32768)=32768.
//   - mag = abs(re)+abs(im), saturated to 2^(BIT_WIDTH+1)-1; max 65536 fits in 17 bits.
// - Peak:
//   - Update on FIFO push when mag > running max (strict), so ties keep the lowest bin.
//   - Bin 0 is skipped if SKIP_DC.
//   - All-zero frame -> peak_bin=1 (SKIP_DC) or 0, peak_mag=0.
// - Bins streamed strictly in order 0..NUM_BINS-1; exactly one mag_last per frame.
// STRUCTURE
// - fft_pkg:
//   - Localparams BIT_WIDTH, N, NUM_BINS, MAG_W=BIT_WIDTH+1.
//   - typedef mag_t (logic [MAG_W-1:0]) and bin_t (logic [N-2:0]).
//   - typedef enum unload_state_t {IDLE, READ, DRAIN, REARM}.
// - Sub-module mag_skid_fifo: 2-entry sync FIFO of {mag, bin, last}, with push/pop/count.
//   The parent holds the FSM, issue counter, in-flight flag and peak tracker.
// TESTING
// - Reset, then hold fft_done=0 for 20 cycles -> rd_active=0, mag_valid=0, add_rd=0 throughout.
// - RAM model: bin k = {k, -k}, mag_ready=1; pulse fft_done.
//   -> 256 beats on consecutive cycles, mag=2k, mag_last only at bin 255.
//   -> frame_done one cycle later; peak_bin=255, peak_mag=510.
// - Same model, mag_ready random 30%.
//   -> Every bin 0..255 appears once, in order; beat fields stable while stalled.
// - Corner values: bin 3={-32768,-32768} and bin 0={32767,0}, others 0.
//   -> bin 3 mag=65536 (no wrap); peak_bin=3 with DC skipped.
// - Ties: bin 10 and bin 20 both mag=500, all others lower -> peak_bin=10.
//   fft_done held high through REARM -> no second frame.
// - reset low at bin 100 mid-frame, released, then fft_done pulsed.
//   -> Outputs cleared on the reset edge; new frame starts at bin 0 with a complete 256-beat stream.

Source files
------------

// File: rtl/fft_unload_pkg.sv
// Shared types and constants for the FFT result unloader.
package fft_pkg;

  localparam int BIT_WIDTH = 16;
  localparam int N         = 9;
  localparam int NUM_BINS  = 2 ** (N - 1);
  localparam int MAG_W     = BIT_WIDTH + 1;
  localparam bit SKIP_DC   = 1'b1;

  typedef logic [MAG_W-1:0] mag_t;
  typedef logic [N-2:0]     bin_t;

  localparam bin_t LAST_BIN = bin_t'(NUM_BINS - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, REARM} unload_state_t;

  typedef struct packed {
    mag_t mag;
    bin_t bin;
    logic last;
  } beat_t;

  // |re|+|im| with one guard bit so abs(-2^(BIT_WIDTH-1)) does not wrap
  function automatic mag_t l1_mag(input logic [2*BIT_WIDTH-1:0] word);
    logic signed [MAG_W-1:0] re;
    logic signed [MAG_W-1:0] im;
    logic [MAG_W-1:0]        abs_re;
    logic [MAG_W-1:0]        abs_im;
    logic [MAG_W:0]          sum;
    re     = {word[2*BIT_WIDTH-1], word[2*BIT_WIDTH-1:BIT_WIDTH]};
    im     = {word[BIT_WIDTH-1], word[BIT_WIDTH-1:0]};
    abs_re = re[MAG_W-1] ? MAG_W'(-re) : MAG_W'(re);
    abs_im = im[MAG_W-1] ? MAG_W'(-im) : MAG_W'(im);
    sum    = {1'b0, abs_re} + {1'b0, abs_im};
    return sum[MAG_W] ? {MAG_W{1'b1}} : sum[MAG_W-1:0];
  endfunction

endpackage

// File: rtl/fft_unload_if.sv
// Magnitude beat stream from the unloader to its downstream consumer.
interface fft_unload_if;
  import fft_pkg::*;

  logic mag_valid;
  logic mag_ready;
  mag_t mag;
  bin_t mag_bin;
  logic mag_last;

  modport master (output mag_valid, output mag, output mag_bin, output mag_last, input mag_ready);
  modport slave  (input mag_valid, input mag, input mag_bin, input mag_last, output mag_ready);

endinterface

// File: rtl/fft_unload_mag_skid_fifo.sv
// Two-entry FIFO of magnitude beats; covers the one-cycle RAM read latency under backpressure.
module mag_skid_fifo
  import fft_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  beat_t      din,
  output beat_t      dout,
  output logic [1:0] count
);

  beat_t mem [2];
  logic  wr_ptr;
  logic  rd_ptr;

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/fft_unload.sv
// Sweeps the FFT result RAM after fft_done, streams L1 magnitudes and reports the frame peak.
module fft_unload
  import fft_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   fft_done,
  input  logic [2*BIT_WIDTH-1:0] dout,
  output logic [N-1:0]           add_rd,
  output logic                   rd_active,
  fft_unload_if.master           mag_if,
  output logic                   frame_done,
  output bin_t                   peak_bin,
  output mag_t                   peak_mag
);

  unload_state_t state_q, state_d;
  bin_t          issue_cnt;
  logic          inflight;
  bin_t          inflight_bin;
  logic [1:0]    fifo_count;
  beat_t         push_beat;
  beat_t         head;
  mag_t          cur_mag;
  mag_t          run_max;
  bin_t          run_bin;
  logic          issue;
  logic          start;
  logic          pop;
  logic          room;
  logic          last_accept;

  assign cur_mag     = l1_mag(dout);
  assign push_beat   = '{mag: cur_mag, bin: inflight_bin, last: (inflight_bin == LAST_BIN)};
  assign pop         = mag_if.mag_valid & mag_if.mag_ready;
  assign last_accept = pop & head.last & (state_q == DRAIN);
  // A slot freed by this cycle's pop can be reused by a read issued now
  assign room        = ({1'b0, fifo_count} + 3'(inflight) - 3'(pop)) < 3'd2;

  assign mag_if.mag_valid = (fifo_count != 2'd0);
  assign mag_if.mag       = head.mag;
  assign mag_if.mag_bin   = head.bin;
  assign mag_if.mag_last  = head.last;

  mag_skid_fifo u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (inflight),
    .pop   (pop),
    .din   (push_beat),
    .dout  (head),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    issue     = 1'b0;
    start     = 1'b0;
    rd_active = 1'b0;
    add_rd    = '0;
    unique case (state_q)
      IDLE: begin
        if (fft_done) begin
          state_d = READ;
          start   = 1'b1;
        end
      end
      READ: begin
        rd_active = 1'b1;
        add_rd    = {1'b0, issue_cnt};
        if (room) begin
          issue = 1'b1;
          if (issue_cnt == LAST_BIN) state_d = DRAIN;
        end
      end
      DRAIN: begin
        rd_active = 1'b1;
        if (last_accept) state_d = REARM;
      end
      REARM: begin
        if (!fft_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      issue_cnt    <= '0;
      inflight     <= 1'b0;
      inflight_bin <= '0;
      run_max      <= '0;
      run_bin      <= '0;
      frame_done   <= 1'b0;
      peak_bin     <= '0;
      peak_mag     <= '0;
    end else begin
      frame_done <= last_accept;
      inflight   <= issue;
      if (issue) begin
        inflight_bin <= issue_cnt;
        issue_cnt    <= issue_cnt + 1'b1;
      end
      // Strict compare keeps the lowest bin on ties
      if (start) begin
        issue_cnt <= '0;
        run_max   <= '0;
        run_bin   <= SKIP_DC ? bin_t'(1) : bin_t'(0);
      end else if (inflight && !(SKIP_DC && inflight_bin == '0) && cur_mag > run_max) begin
        run_max <= cur_mag;
        run_bin <= inflight_bin;
      end
      if (last_accept) begin
        peak_bin <= run_bin;
        peak_mag <= run_max;
      end
    end
  end

endmodule

// File: tb/tb_fft_unload.sv
// Randomized self-checking bench for fft_unload against a bin-level behavioural model.
module tb_fft_unload;
  import fft_pkg::*;

  logic                   clk;
  logic                   reset;
  logic                   fft_done;
  logic [2*BIT_WIDTH-1:0] dout;
  logic [N-1:0]           add_rd;
  logic                   rd_active;
  logic                   frame_done;
  bin_t                   peak_bin;
  mag_t                   peak_mag;

  fft_unload_if mag_if ();

  int ram_re [256];
  int ram_im [256];
  int checks   = 0;
  int failures = 0;

  fft_unload dut (
    .clk        (clk),
    .reset      (reset),
    .fft_done   (fft_done),
    .dout       (dout),
    .add_rd     (add_rd),
    .rd_active  (rd_active),
    .mag_if     (mag_if),
    .frame_done (frame_done),
    .peak_bin   (peak_bin),
    .peak_mag   (peak_mag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Result RAM: registered read, data valid the cycle after the address
  always @(posedge clk) begin
    dout <= {16'(ram_re[add_rd[7:0]]), 16'(ram_im[add_rd[7:0]])};
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  function automatic int model_mag(input int k);
    int a, b, s;
    a = (ram_re[k] < 0) ? -ram_re[k] : ram_re[k];
    b = (ram_im[k] < 0) ? -ram_im[k] : ram_im[k];
    s = a + b;
    return (s > 131071) ? 131071 : s;
  endfunction

  task automatic model_peak(output int pb, output int pm);
    pb = SKIP_DC ? 1 : 0;
    pm = 0;
    for (int k = (SKIP_DC ? 1 : 0); k < 256; k++) begin
      if (model_mag(k) > pm) begin
        pm = model_mag(k);
        pb = k;
      end
    end
  endtask

  // Runs one frame and checks every accepted beat, stall stability, frame_done and the peak
  task automatic applyStimulus(input int ready_pct, input bit hold_done);
    int   exp_idx = 0;
    int   cyc = 0;
    int   first_cyc = -1;
    int   last_cyc = -1;
    int   early_done = 0;
    int   pb, pm;
    bit   stalled = 1'b0;
    mag_t prev_mag;
    bin_t prev_bin;
    logic prev_last;
    model_peak(pb, pm);
    @(negedge clk);
    fft_done = 1'b1;
    while (exp_idx < 256 && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 3 && !hold_done) fft_done = 1'b0;
      mag_if.mag_ready = ($urandom_range(0, 99) < ready_pct);
      #1;
      if (frame_done) early_done++;
      if (stalled) begin
        checkOutput("stall_valid", mag_if.mag_valid, 1);
        checkOutput("stall_mag", mag_if.mag, prev_mag);
        checkOutput("stall_bin", mag_if.mag_bin, prev_bin);
        checkOutput("stall_last", mag_if.mag_last, prev_last);
      end
      if (mag_if.mag_valid && mag_if.mag_ready) begin
        checkOutput("beat_bin", mag_if.mag_bin, exp_idx);
        checkOutput("beat_mag", mag_if.mag, model_mag(exp_idx));
        checkOutput("beat_last", mag_if.mag_last, (exp_idx == 255));
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        exp_idx++;
      end
      stalled   = mag_if.mag_valid && !mag_if.mag_ready;
      prev_mag  = mag_if.mag;
      prev_bin  = mag_if.mag_bin;
      prev_last = mag_if.mag_last;
    end
    checkOutput("frame_beats", exp_idx, 256);
    checkOutput("early_frame_done", early_done, 0);
    if (ready_pct == 100) checkOutput("back_to_back", last_cyc - first_cyc, 255);
    @(negedge clk);
    mag_if.mag_ready = 1'b1;
    #1;
    checkOutput("frame_done", frame_done, 1);
    checkOutput("peak_bin", peak_bin, pb);
    checkOutput("peak_mag", peak_mag, pm);
    checkOutput("no_extra_beat", mag_if.mag_valid, 0);
    @(negedge clk);
    #1;
    checkOutput("frame_done_pulse", frame_done, 0);
    checkOutput("peak_held", peak_bin, pb);
  endtask

  task automatic fill_random(input int span);
    for (int k = 0; k < 256; k++) begin
      ram_re[k] = int'($urandom_range(0, 2 * span)) - span;
      ram_im[k] = int'($urandom_range(0, 2 * span)) - span;
      if (ram_re[k] < -32768) ram_re[k] = -32768;
      if (ram_im[k] < -32768) ram_im[k] = -32768;
      if (ram_re[k] > 32767)  ram_re[k] = 32767;
      if (ram_im[k] > 32767)  ram_im[k] = 32767;
    end
  endtask

  initial begin
    int bad;
    int cyc;
    bit seen;
    reset            = 1'b0;
    fft_done         = 1'b0;
    mag_if.mag_ready = 1'b0;
    for (int k = 0; k < 256; k++) begin
      ram_re[k] = 0;
      ram_im[k] = 0;
    end
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_add_rd", add_rd, 0);
    checkOutput("rst_rd_active", rd_active, 0);
    checkOutput("rst_mag_valid", mag_if.mag_valid, 0);
    checkOutput("rst_frame_done", frame_done, 0);
    checkOutput("rst_peak_bin", peak_bin, 0);
    checkOutput("rst_peak_mag", peak_mag, 0);
    reset = 1'b1;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      checkOutput("idle_rd_active", rd_active, 0);
      checkOutput("idle_mag_valid", mag_if.mag_valid, 0);
      checkOutput("idle_add_rd", add_rd, 0);
    end

    for (int k = 0; k < 256; k++) begin
      ram_re[k] = k;
      ram_im[k] = -k;
    end
    applyStimulus(100, 1'b0);
    applyStimulus(30, 1'b0);

    for (int k = 0; k < 256; k++) begin
      ram_re[k] = 0;
      ram_im[k] = 0;
    end
    ram_re[0] = 32767;
    ram_re[3] = -32768;
    ram_im[3] = -32768;
    applyStimulus(70, 1'b0);

    for (int k = 0; k < 256; k++) begin
      ram_re[k] = 0;
      ram_im[k] = 0;
    end
    applyStimulus(100, 1'b0);

    fill_random(200);
    ram_re[10] = 250;
    ram_im[10] = -250;
    ram_re[20] = -100;
    ram_im[20] = 400;
    applyStimulus(100, 1'b1);
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      #1;
      if (rd_active || mag_if.mag_valid || frame_done) bad++;
    end
    checkOutput("no_restart", bad, 0);
    fft_done = 1'b0;
    repeat (3) @(negedge clk);

    fill_random(40000);
    @(negedge clk);
    fft_done         = 1'b1;
    mag_if.mag_ready = 1'b1;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 3) fft_done = 1'b0;
      #1;
      if (mag_if.mag_valid && mag_if.mag_bin == 8'd100) seen = 1'b1;
    end
    checkOutput("reach_bin100", seen, 1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("midrst_mag_valid", mag_if.mag_valid, 0);
    checkOutput("midrst_rd_active", rd_active, 0);
    checkOutput("midrst_add_rd", add_rd, 0);
    checkOutput("midrst_frame_done", frame_done, 0);
    checkOutput("midrst_peak_bin", peak_bin, 0);
    checkOutput("midrst_peak_mag", peak_mag, 0);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    checkOutput("postrst_mag_valid", mag_if.mag_valid, 0);
    applyStimulus(60, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
